sign_extender: RTL and testbench



---
 rtl/sign_ext_pkg.sv | 20 ++
 rtl/sign_ext_core.sv | 34 +++
 rtl/sign_extender.sv | 81 ++++++++
 tb/tb_sign_extender.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sign_ext_pkg.sv
// -----------------------------------------------------------------------------
// sign_ext_pkg
// Shared definitions for the decode-stage immediate extender.
//   ext_mode_e : 2-bit extension mode (ext_sel encoding)
//   IMM_W      : default immediate width
//   DATA_W     : default datapath width
// -----------------------------------------------------------------------------
package sign_ext_pkg;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    EXT_SEXT  = 2'b00,  // sign-extend from the immediate's MSB
    EXT_ZEXT  = 2'b01,  // zero-extend
    EXT_SEXT8 = 2'b10,  // sign-extend from bit 7, upper immediate bits ignored
    EXT_UPPER = 2'b11   // immediate placed in the top bits, low bits zero
  } ext_mode_e;

endpackage : sign_ext_pkg

// File: rtl/sign_ext_core.sv
// -----------------------------------------------------------------------------
// sign_ext_core
// Combinational mode mux that widens an IN_W-bit immediate to OUT_W bits.
// Pure bit placement; no arithmetic.
// Ports:
//   in_data  [IN_W-1:0]  raw immediate
//   ext_sel  [1:0]       extension mode (see sign_ext_pkg::ext_mode_e)
//   se_comb  [OUT_W-1:0] extended result
// -----------------------------------------------------------------------------
module sign_ext_core
  import sign_ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = DATA_W
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       ext_sel,
  output logic [OUT_W-1:0] se_comb
);

  always_comb begin
    // NOTE: give every always_comb output a default first so no path can
    // leave it unassigned and infer a latch.
    se_comb = '0;
    case (ext_mode_e'(ext_sel))
      EXT_SEXT:  se_comb = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
      EXT_ZEXT:  se_comb = {{(OUT_W-IN_W){1'b0}}, in_data};
      EXT_SEXT8: se_comb = {{(OUT_W-8){in_data[7]}}, in_data[7:0]};
      EXT_UPPER: se_comb = {in_data, {(OUT_W-IN_W){1'b0}}};
      default:   se_comb = '0;
    endcase
  end

endmodule : sign_ext_core

// File: rtl/sign_extender.sv
// -----------------------------------------------------------------------------
// sign_extender
// Registered immediate extender for the decode stage. Produces a zero-latency
// combinational extension and a one-cycle registered copy with a valid flag.
// Optional feature (macro SIGN_EXTENDER_SHL2_EN): branch offset outputs equal
// to the extended value shifted left by two, combinational and registered.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/ext_sel valid this cycle
//   in_data    [IN_W-1:0] raw immediate
//   ext_sel    [1:0] mode: 00 SEXT, 01 ZEXT, 10 SEXT8, 11 UPPER
//   se_comb    [OUT_W-1:0] combinational extension of current inputs
//   se_out     [OUT_W-1:0] registered extension (holds when in_valid=0)
//   br_off     [OUT_W-1:0] se_comb << 2        (SIGN_EXTENDER_SHL2_EN only)
//   br_off_q   [OUT_W-1:0] registered br_off   (SIGN_EXTENDER_SHL2_EN only)
//   out_valid  se_out was captured from a valid input on the last edge
// -----------------------------------------------------------------------------
module sign_extender
  import sign_ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       ext_sel,
  output logic [OUT_W-1:0] se_comb,
  output logic [OUT_W-1:0] se_out,
`ifdef SIGN_EXTENDER_SHL2_EN
  output logic [OUT_W-1:0] br_off,
  output logic [OUT_W-1:0] br_off_q,
`endif
  output logic             out_valid
);

  // SEXT8 reads bit 7, so the immediate needs at least 8 bits, and there must
  // be room above it to extend into.
  if (IN_W < 8 || OUT_W <= IN_W) begin : g_bad_params
    $error("sign_extender: require IN_W >= 8 and OUT_W > IN_W");
  end

  sign_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data (in_data),
    .ext_sel (ext_sel),
    .se_comb (se_comb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        se_out <= se_comb;
      end
    end
  end

`ifdef SIGN_EXTENDER_SHL2_EN
  // Word-offset to byte-offset: top two bits fall off, zeros come in.
  assign br_off = {se_comb[OUT_W-3:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_off_q <= '0;
    end else if (in_valid) begin
      br_off_q <= br_off;
    end
  end
`endif

endmodule : sign_extender

// File: tb/tb_sign_extender.sv
// -----------------------------------------------------------------------------
// tb_sign_extender
// Self-checking bench for sign_extender at default widths (16 -> 32).
// Expected values come from an arithmetic reference model and directed
// constants; the registered path is tracked by a one-entry model register.
// -----------------------------------------------------------------------------
module tb_sign_extender;
  import sign_ext_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  ext_sel;
  logic [31:0] se_comb;
  logic [31:0] se_out;
  logic        out_valid;
`ifdef SIGN_EXTENDER_SHL2_EN
  logic [31:0] br_off;
  logic [31:0] br_off_q;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model of the registered outputs.
  logic [31:0] model_q;
  logic        model_v;
  logic [31:0] model_br_q;

  sign_extender #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .ext_sel   (ext_sel),
    .se_comb   (se_comb),
    .se_out    (se_out),
`ifdef SIGN_EXTENDER_SHL2_EN
    .br_off    (br_off),
    .br_off_q  (br_off_q),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret the immediate as a number and rebuild the 32-bit
  // two's-complement value with integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [1:0] sel, input logic [15:0] d);
    longint x;
    x = longint'(d);
    case (sel)
      2'd0: if (x >= 32768) x = x - 65536;
      2'd1: x = x;
      2'd2: begin
        x = x % 256;
        if (x >= 128) x = x - 256;
      end
      default: x = x * 65536;
    endcase
    return 32'(x);
  endfunction

  function automatic logic [31:0] ref_br(input logic [31:0] v);
    return 32'(longint'(v) * 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // then check registered outputs 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [1:0] sel, input logic [15:0] d);
    in_valid = v;
    ext_sel  = sel;
    in_data  = d;
    #1;
    check("se_comb", se_comb, ref_ext(sel, d));
`ifdef SIGN_EXTENDER_SHL2_EN
    check("br_off", br_off, ref_br(ref_ext(sel, d)));
`endif
    @(posedge clk);
    #1;
    if (rst_n) begin
      model_v = v;
      if (v) begin
        model_q    = ref_ext(sel, d);
        model_br_q = ref_br(model_q);
      end
    end
    check("se_out", se_out, model_q);
    check("out_valid", 32'(out_valid), 32'(model_v));
`ifdef SIGN_EXTENDER_SHL2_EN
    check("br_off_q", br_off_q, model_br_q);
`endif
    @(negedge clk);
  endtask

  initial begin
    model_q    = '0;
    model_v    = 1'b0;
    model_br_q = '0;

    // Reset held with a valid all-ones input present.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    ext_sel  = EXT_SEXT;
    repeat (3) @(posedge clk);
    #1;
    check("rst_se_out", se_out, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
`ifdef SIGN_EXTENDER_SHL2_EN
    check("rst_br_off_q", br_off_q, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, EXT_SEXT, 16'hFFFF);
    check("plan_rel_sext", se_out, 32'hFFFFFFFF);
    check("plan_rel_valid", 32'(out_valid), 32'h1);

    // SEXT sequence.
    step(1'b1, EXT_SEXT, 16'h0000);
    check("plan_sext_0000", se_out, 32'h00000000);
    step(1'b1, EXT_SEXT, 16'h4000);
    check("plan_sext_4000", se_out, 32'h00004000);
`ifdef SIGN_EXTENDER_SHL2_EN
    check("plan_br_q_4000", br_off_q, 32'h00010000);
`endif
    step(1'b1, EXT_SEXT, 16'h3FFF);
    check("plan_sext_3fff", se_out, 32'h00003FFF);
    step(1'b1, EXT_SEXT, 16'h8000);
    check("plan_sext_8000", se_out, 32'hFFFF8000);

    // Mode sweep on 16'h80F0.
    step(1'b1, EXT_ZEXT, 16'h80F0);
    check("plan_zext_80f0", se_out, 32'h000080F0);
    step(1'b1, EXT_SEXT8, 16'h80F0);
    check("plan_sext8_80f0", se_out, 32'hFFFFFFF0);
    step(1'b1, EXT_UPPER, 16'h80F0);
    check("plan_upper_80f0", se_out, 32'h80F00000);
    step(1'b1, EXT_SEXT, 16'h80F0);
    check("plan_sext_80f0", se_out, 32'hFFFF80F0);

    // Boundary patterns across every mode.
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 2'(m), 16'h0000);
      check("zero_all_modes", se_out, 32'h0);
      step(1'b1, 2'(m), 16'hFFFF);
    end
    step(1'b1, EXT_SEXT8, 16'hFFFF);
    check("ones_sext8", se_out, 32'hFFFFFFFF);
    step(1'b1, EXT_ZEXT, 16'hFFFF);
    check("ones_zext", se_out, 32'h0000FFFF);
    // SEXT8 ignores the upper immediate bits.
    step(1'b1, EXT_SEXT8, 16'h7F80);
    check("sext8_ignore_hi", se_out, 32'hFFFFFF80);

`ifdef SIGN_EXTENDER_SHL2_EN
    in_valid = 1'b0;
    ext_sel  = EXT_SEXT;
    in_data  = 16'hFFFF;
    #1;
    check("plan_br_ffff", br_off, 32'hFFFFFFFC);
`endif

    // Valid gap: se_out holds, out_valid drops.
    step(1'b1, EXT_SEXT, 16'h0001);
    check("gap_capture", se_out, 32'h00000001);
    step(1'b0, EXT_UPPER, 16'hABCD);
    check("gap_hold1", se_out, 32'h00000001);
    check("gap_valid1", 32'(out_valid), 32'h0);
    step(1'b0, EXT_SEXT, 16'h8000);
    check("gap_hold2", se_out, 32'h00000001);

    // Asynchronous reset mid-hold, no clock edge involved.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_se_out", se_out, 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    model_q    = '0;
    model_v    = 1'b0;
    model_br_q = '0;
    @(negedge clk);
    // A valid input while reset is held is not captured.
    step(1'b1, EXT_ZEXT, 16'h1234);
    rst_n = 1'b1;

    // Pending valid discarded by reset asserted before its edge.
    in_valid = 1'b1;
    ext_sel  = EXT_ZEXT;
    in_data  = 16'h5555;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("pending_discard", se_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sign_extender
